// File: rtl/sm4_mode_ctrl.sv
// Block-mode sequencer in front of a single-block SM4 core: input FIFO,
// ready/valid streaming and ECB/CBC/CTR chaining with one block in flight.
module sm4_mode_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CTR_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_load_i,
  input  logic [1:0]       mode_i,
  input  logic             dec_i,
  input  logic [127:0]     iv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             core_valid_o,
  output logic             core_dec_o,
  output logic [127:0]     core_data_o,
  input  logic             core_valid_i,
  input  logic [127:0]     core_data_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2,
    MODE_ILL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic             dec_q;
  logic [127:0]     chain_q, chain_d;
  logic [127:0]     blk_q;
  logic [127:0]     out_q, out_d;
  logic [127:0]     core_in;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [127:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, push, pop;
  logic [127:0]     fifo_head;

  logic             issue, capture, out_hs;
  logic             cfg_ok, cfg_err;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = in_valid_i && !full;
  assign pop       = issue;
  assign fifo_head = mem_q[rd_ptr_q];

  assign busy_o  = (state_q != ST_IDLE) || !empty;
  assign cfg_ok  = cfg_load_i && !busy_o && (mode_i != MODE_ILL);
  assign cfg_err = cfg_load_i && (busy_o || (mode_i == MODE_ILL));

  // NOTE: FIFO storage is deliberately left out of reset; entries are only
  // read after being written, so resetting them would just cost flops.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    out_hs  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (core_valid_i) begin
        capture = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: if (out_ready_i) begin
        out_hs  = 1'b1;
        state_d = empty ? ST_IDLE : ST_ISSUE;
      end
    endcase
  end

  always_comb begin
    core_in = fifo_head;
    out_d   = core_data_i;
    chain_d = chain_q;
    unique case (mode_q)
      MODE_CBC: begin
        if (dec_q) begin
          out_d   = core_data_i ^ chain_q;
          chain_d = blk_q;
        end else begin
          core_in = fifo_head ^ chain_q;
          chain_d = core_data_i;
        end
      end
      MODE_CTR: begin
        core_in = chain_q;
        out_d   = core_data_i ^ blk_q;
        chain_d[CTR_W-1:0] = chain_q[CTR_W-1:0] + CTR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q  <= MODE_ECB;
      dec_q   <= 1'b0;
      chain_q <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A config load can only land in IDLE, so it never races a capture.
      if (cfg_ok) begin
        mode_q  <= mode_e'(mode_i);
        dec_q   <= dec_i;
        chain_q <= iv_i;
      end else if (capture) begin
        chain_q <= chain_d;
      end
      if (cfg_err) err_q <= 1'b1;
      if (pop)     blk_q <= fifo_head;
      if (capture) out_q <= out_d;
      if (cfg_ok)      cnt_q <= '0;
      else if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready_o   = !full;
  assign out_valid_o  = (state_q == ST_OUT);
  assign out_data_o   = out_q;
  assign core_valid_o = issue;
  assign core_data_o  = issue ? core_in : '0;
  assign core_dec_o   = (mode_q == MODE_CTR) ? 1'b0 : dec_q;
  assign err_o        = err_q;
  assign blk_cnt_o    = cnt_q;

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Bench for sm4_mode_ctrl: model core with programmable latency, transaction
// level chaining model, directed scenarios plus randomized streams.
module tb_sm4_mode_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CTR_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [127:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic             clk;
  logic             rst_i;
  logic             cfg_load_i;
  logic [1:0]       mode_i;
  logic             dec_i;
  logic [127:0]     iv_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [127:0]     in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [127:0]     out_data_o;
  logic             core_valid_o;
  logic             core_dec_o;
  logic [127:0]     core_data_o;
  logic             core_valid_i;
  logic [127:0]     core_data_i;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] blk_cnt_o;

  sm4_mode_ctrl #(.DEPTH(DEPTH), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_load_i  (cfg_load_i),
    .mode_i      (mode_i),
    .dec_i       (dec_i),
    .iv_i        (iv_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .core_valid_o(core_valid_o),
    .core_dec_o  (core_dec_o),
    .core_data_o (core_data_o),
    .core_valid_i(core_valid_i),
    .core_data_i (core_data_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  typedef struct {
    logic [127:0] data;
    logic         dec;
  } core_exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  int core_kind = 1;
  int ready_mode = 1;
  int t_core = 0;

  // Reference model state: configuration, chain value, expectations.
  int               m_mode = 0;
  logic             m_dec = 1'b0;
  logic [127:0]     m_c = '0;
  logic             m_err = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  core_exp_t        exp_core[$];
  logic [127:0]     exp_out[$];
  logic [127:0]     got_out[$];
  logic [127:0]     core_seen[$];
  logic             dec_seen[$];

  // Core model private state.
  bit           pend = 0;
  int           rem = 0;
  logic [127:0] resp = '0;
  core_exp_t    ce;
  bit           hold_v = 0;
  logic [127:0] hold_d = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] core_fn(input logic [127:0] x, input logic d);
    logic [127:0] y;
    if (core_kind == 0) return x;
    if (d) begin
      y = x ^ KEY;
      return {y[0], y[127:1]};
    end
    return {x[126:0], x[127]} ^ KEY;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] next_out();
    if (got_out.size() == 0) return 'x;
    return got_out.pop_front();
  endfunction

  function automatic logic [127:0] next_core();
    if (core_seen.size() == 0) return 'x;
    return core_seen.pop_front();
  endfunction

  // Expected core input and result for one accepted block, in stream order.
  function automatic void model_push(input logic [127:0] p);
    core_exp_t e;
    logic [127:0] r;
    case (m_mode)
      1: begin
        if (m_dec) begin
          e.data = p;
          e.dec  = 1'b1;
          r = core_fn(p, 1'b1) ^ m_c;
          m_c = p;
        end else begin
          e.data = p ^ m_c;
          e.dec  = 1'b0;
          r = core_fn(e.data, 1'b0);
          m_c = r;
        end
      end
      2: begin
        e.data = m_c;
        e.dec  = 1'b0;
        r = core_fn(m_c, 1'b0) ^ p;
        m_c[31:0] = m_c[31:0] + 32'd1;
      end
      default: begin
        e.data = p;
        e.dec  = m_dec;
        r = core_fn(p, m_dec);
      end
    endcase
    exp_core.push_back(e);
    exp_out.push_back(r);
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_dec  = 1'b0;
    m_c    = '0;
    m_err  = 1'b0;
    m_cnt  = '0;
    exp_core.delete();
    exp_out.delete();
  endfunction

  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Model core: answers each start pulse lat cycles later.
  initial begin
    core_valid_i = 1'b0;
    core_data_i  = '0;
    forever begin
      @(negedge clk);
      core_valid_i = 1'b0;
      if (pend) begin
        rem--;
        if (rem <= 0) begin
          core_valid_i = 1'b1;
          core_data_i  = resp;
          pend = 0;
        end
      end
      if (core_valid_o) begin
        t_core = cyc;
        core_seen.push_back(core_data_o);
        dec_seen.push_back(core_dec_o);
        if (exp_core.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL core_unexpected got=%h exp=none", core_data_o);
        end else begin
          ce = exp_core.pop_front();
          check("core_data", core_data_o, ce.data);
          check("core_dec", 128'(core_dec_o), 128'(ce.dec));
        end
        resp = core_fn(core_data_o, core_dec_o);
        rem  = lat;
        pend = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid_o) begin
        if (hold_v) check("out_stable", out_data_o, hold_d);
        if (out_ready_i) begin
          if (exp_out.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_unexpected got=%h exp=none", out_data_o);
          end else begin
            check("out_data", out_data_o, exp_out.pop_front());
          end
          got_out.push_back(out_data_o);
          m_cnt  = m_cnt + 1'b1;
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_d = out_data_o;
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_block(input logic [127:0] d);
    int   n;
    logic acc;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    do begin
      @(negedge clk);
      acc = in_ready_o;
      if (acc) model_push(d);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    in_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout got=blocked exp=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_out.size() != 0 || busy_o) && n < 3000) begin
      step(1);
      n++;
    end
    check("drain_idle", 128'(busy_o), 128'd0);
    check("drain_pending", 128'(exp_out.size()), 128'd0);
  endtask

  task automatic cfg(input logic [1:0] m, input logic d, input logic [127:0] iv, input bit is_busy);
    bit ok;
    ok = (m != 2'd3) && !is_busy;
    cfg_load_i = 1'b1;
    mode_i     = m;
    dec_i      = d;
    iv_i       = iv;
    step(1);
    cfg_load_i = 1'b0;
    if (ok) begin
      m_mode = int'(m);
      m_dec  = d;
      m_c    = iv;
      m_cnt  = '0;
    end else begin
      m_err = 1'b1;
    end
    check("cfg_err", 128'(err_o), 128'(m_err));
    check("cfg_cnt", 128'(blk_cnt_o), 128'(m_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p0, p1, c0, c1, iv, pt, ctr_iv;
    logic [127:0] blks [6];
    int t_push, t_out, idx, n, nb;
    bit acc;

    rst_i = 1'b1;
    cfg_load_i = 1'b0;
    mode_i = '0;
    dec_i = 1'b0;
    iv_i = '0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    step(3);
    check("rst_in_ready", 128'(in_ready_o), 128'd1);
    check("rst_out_valid", 128'(out_valid_o), 128'd0);
    check("rst_out_data", out_data_o, 128'd0);
    check("rst_core_valid", 128'(core_valid_o), 128'd0);
    check("rst_core_dec", 128'(core_dec_o), 128'd0);
    check("rst_core_data", core_data_o, 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_blk_cnt", 128'(blk_cnt_o), 128'd0);
    rst_i = 1'b0;
    step(1);

    // ECB with the standard plaintext and a 32-cycle core.
    core_kind = 1;
    lat = 32;
    cfg(2'd0, 1'b0, '0, 0);
    pt = 128'h0123456789abcdeffedcba9876543210;
    core_seen.delete();
    t_push = cyc;
    push_block(pt);
    n = 0;
    while (!out_valid_o && n < 100) begin
      step(1);
      n++;
    end
    t_out = cyc;
    check("ecb_core_in", next_core(), pt);
    check("ecb_issue_lat", 128'(t_core - t_push), 128'd2);
    check("ecb_out_lat", 128'(t_out - t_push), 128'd35);
    check("ecb_out", out_data_o, core_fn(pt, 1'b0));
    drain();
    check("ecb_cnt", 128'(blk_cnt_o), 128'd1);

    // CBC encrypt then decrypt with an identity core.
    core_kind = 0;
    lat = 2;
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    p0 = rand128();
    p1 = rand128();
    c0 = p0 ^ iv;
    c1 = p1 ^ c0;
    got_out.delete();
    cfg(2'd1, 1'b0, iv, 0);
    push_block(p0);
    push_block(p1);
    drain();
    check("cbc_enc0", next_out(), c0);
    check("cbc_enc1", next_out(), c1);
    cfg(2'd1, 1'b1, iv, 0);
    push_block(c0);
    push_block(c1);
    drain();
    check("cbc_dec0", next_out(), p0);
    check("cbc_dec1", next_out(), p1);

    // CTR counter wrap in the low word; direction forced to encrypt.
    core_kind = 1;
    lat = 3;
    ctr_iv = {96'h1234, 32'hffffffff};
    core_seen.delete();
    dec_seen.delete();
    cfg(2'd2, 1'b1, ctr_iv, 0);
    push_block(rand128());
    push_block(rand128());
    drain();
    check("ctr_core0", next_core(), ctr_iv);
    check("ctr_core1", next_core(), {96'h1234, 32'h0});
    check("ctr_dec", 128'(dec_seen.size() > 0 ? dec_seen[dec_seen.size()-1] : 1'bx), 128'd0);

    // FIFO full: no consumer, six back-to-back pushes.
    lat = 3;
    cfg(2'd0, 1'b0, '0, 0);
    ready_mode = 0;
    step(1);
    for (int i = 0; i < 6; i++) blks[i] = rand128();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (idx < 6);
      in_data_i  = blks[idx < 6 ? idx : 5];
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      if (acc) model_push(blks[idx]);
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid_i = 1'b0;
    check("fifo_accepted", 128'(idx), 128'd5);
    check("fifo_full_ready", 128'(in_ready_o), 128'd0);
    ready_mode = 1;
    while (idx < 6) begin
      push_block(blks[idx]);
      idx++;
    end
    drain();
    check("fifo_cnt", 128'(blk_cnt_o), 128'd6);

    // Randomized streams across modes, latencies and backpressure.
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 6);
      ready_mode = 2;
      cfg(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rand128(), 0);
      nb = $urandom_range(4, 10);
      for (int b = 0; b < nb; b++) begin
        push_block(rand128());
        step($urandom_range(0, 2));
      end
      drain();
      check("rand_cnt", 128'(blk_cnt_o), 128'(nb));
    end
    ready_mode = 1;

    // Configuration errors: load while busy, then illegal mode.
    lat = 10;
    cfg(2'd1, 1'b0, rand128(), 0);
    push_block(rand128());
    push_block(rand128());
    cfg(2'd2, 1'b1, rand128(), 1);
    drain();
    cfg(2'd3, 1'b0, rand128(), 0);
    push_block(rand128());
    drain();
    cfg(2'd0, 1'b0, '0, 0);
    check("err_sticky", 128'(err_o), 128'd1);

    // Reset while waiting on the core, followed by a stray core strobe.
    lat = 20;
    cfg(2'd1, 1'b0, rand128(), 0);
    push_block(rand128());
    step(8);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    model_reset();
    step(30);
    check("rst2_out_valid", 128'(out_valid_o), 128'd0);
    check("rst2_busy", 128'(busy_o), 128'd0);
    check("rst2_in_ready", 128'(in_ready_o), 128'd1);
    check("rst2_cnt", 128'(blk_cnt_o), 128'd0);
    check("rst2_err", 128'(err_o), 128'd0);
    lat = 2;
    push_block(rand128());
    drain();
    check("rst2_ecb_cnt", 128'(blk_cnt_o), 128'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
